// File: rtl/rr_arb_lock.sv
// Round-robin arbiter that locks the grant for a whole transaction and rotates
// priority to owner+1 on release. Optional forced release under `RR_TIMEOUT_EN`.
module rr_arb_lock #(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = (REQCNT > 2) ? $clog2(REQCNT) : 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REQCNT-1:0]   req_i,
  input  logic                done_i,
  output logic [REQCNT-1:0]   gnt_o,
  output logic [REQWIDTH-1:0] gnt_num_o,
  output logic                gnt_val_o,
  output logic                timeout_o
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  if (REQCNT < 2 || TIMEOUT < 2) begin : g_param_check
    $error("rr_arb_lock: REQCNT and TIMEOUT must both be >= 2");
  end

  state_e              state_q;
  logic [REQWIDTH-1:0] prior_q, prior_d;
  logic [REQCNT-1:0]   gnt_q;
  logic [REQWIDTH-1:0] gnt_num_q;
  logic                gnt_val_q;
  logic                timeout_q;

  logic                own_req, tmo_hit, release_c, found;
  logic [REQWIDTH-1:0] scan_start, sel_idx;
  logic [REQCNT-1:0]   scan_req;

  // Index arithmetic wraps at REQCNT, not at 2**REQWIDTH.
  function automatic logic [REQWIDTH-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= REQCNT) s -= REQCNT;
    return REQWIDTH'(s);
  endfunction

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt_q;
  assign tmo_hit = (tcnt_q == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    found     = 1'b0;
    sel_idx   = '0;
    own_req   = req_i[gnt_num_q];
    release_c = done_i | ~own_req | tmo_hit;
    prior_d   = (gnt_num_q == REQWIDTH'(REQCNT - 1)) ? '0 : gnt_num_q + 1'b1;
    // While granted, re-arbitration uses the post-release priority and skips the owner.
    scan_start = (state_q == S_GRANT) ? prior_d : prior_q;
    scan_req   = (state_q == S_GRANT) ? (req_i & ~gnt_q) : req_i;
    // Scan downwards so the nearest requester to scan_start is assigned last and wins.
    for (int i = REQCNT - 1; i >= 0; i--) begin
      if (scan_req[wrap_idx(int'(scan_start), i)]) begin
        found   = 1'b1;
        sel_idx = wrap_idx(int'(scan_start), i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      prior_q   <= '0;
      gnt_q     <= '0;
      gnt_num_q <= '0;
      gnt_val_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef RR_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          timeout_q <= 1'b0;
          if (found) begin
            state_q   <= S_GRANT;
            gnt_q     <= REQCNT'(1) << sel_idx;
            gnt_num_q <= sel_idx;
            gnt_val_q <= 1'b1;
`ifdef RR_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (release_c) begin
            prior_q   <= prior_d;
            timeout_q <= tmo_hit & ~done_i & own_req;
            if (found) begin
              gnt_q     <= REQCNT'(1) << sel_idx;
              gnt_num_q <= sel_idx;
`ifdef RR_TIMEOUT_EN
              tcnt_q    <= '0;
`endif
            end else begin
              state_q   <= S_IDLE;
              gnt_q     <= '0;
              gnt_num_q <= '0;
              gnt_val_q <= 1'b0;
            end
          end else begin
            timeout_q <= 1'b0;
`ifdef RR_TIMEOUT_EN
            tcnt_q    <= tcnt_q + CW'(1);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_num_o = gnt_num_q;
  assign gnt_val_o = gnt_val_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arb_lock.sv
// Self-checking bench for rr_arb_lock: directed scenarios plus random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_rr_arb_lock;

  localparam int N  = 5;
  localparam int W  = 3;
  localparam int TO = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_num;
  logic         gnt_val;
  logic         tmo;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: who owns the resource and for how many cycles.
  bit m_val;
  int m_owner;
  int m_prior;
  int m_cycles;
  bit m_tmo;

  rr_arb_lock #(.REQCNT(N), .TIMEOUT(TO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .done_i   (done),
    .gnt_o    (gnt),
    .gnt_num_o(gnt_num),
    .gnt_val_o(gnt_val),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit own, timed;
    int w;
    if (rst) begin
      m_val = 0; m_owner = 0; m_prior = 0; m_cycles = 0; m_tmo = 0;
    end else if (!m_val) begin
      m_tmo = 0;
      w = pick(req, m_prior, -1);
      if (w >= 0) begin
        m_val = 1; m_owner = w; m_cycles = 1;
      end
    end else begin
      own   = req[m_owner];
      timed = TMO_EN && (m_cycles == TO);
      if (done || !own || timed) begin
        m_tmo   = timed && !done && own;
        m_prior = (m_owner + 1) % N;
        w = pick(req, m_prior, m_owner);
        if (w >= 0) begin
          m_owner = w; m_cycles = 1;
        end else begin
          m_val = 0;
        end
      end else begin
        m_cycles++;
        m_tmo = 0;
      end
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic cycle();
    logic [N-1:0] exp_gnt;
    model_step();
    @(posedge clk);
    #1;
    exp_gnt = m_val ? N'(1 << m_owner) : '0;
    check("gnt_val", 32'(gnt_val), 32'(m_val));
    check("gnt", 32'(gnt), 32'(exp_gnt));
    if (m_val) check("gnt_num", 32'(gnt_num), 32'(m_owner));
    check("timeout", 32'(tmo), 32'(m_tmo));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  int order[5] = '{1, 2, 4, 1, 2};

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    m_val = 0; m_owner = 0; m_prior = 0; m_cycles = 0; m_tmo = 0;

    // 1: idle with no requests.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t1_idle_val", 32'(gnt_val), 32'd0);
    end

    // 2: three requesters, 3-cycle transactions, back-to-back rotation.
    do_reset();
    req = 5'b10110;
    cycle();
    for (int g = 0; g < 5; g++) begin
      check("t2_order", 32'(gnt_num), 32'(order[g]));
      done = 1'b0;
      cycle(); cycle();
      done = 1'b1;
      cycle();
      check("t2_no_gap", 32'(gnt_val), 32'd1);
    end
    done = 1'b0;

    // 3: top channel wraps priority back to 0.
    do_reset();
    req = 5'b10000;
    cycle();
    check("t3_gnt4", 32'(gnt_num), 32'd4);
    done = 1'b1; req = '0;
    cycle();
    check("t3_idle", 32'(gnt_val), 32'd0);
    done = 1'b0; req = 5'b01001;
    cycle();
    check("t3_gnt0", 32'(gnt_num), 32'd0);

    // 4: owner aborts by dropping its request.
    do_reset();
    req = 5'b01100;
    cycle();
    check("t4_gnt2", 32'(gnt_num), 32'd2);
    req = 5'b01000;
    cycle();
    check("t4_gnt3", 32'(gnt_num), 32'd3);
    check("t4_val", 32'(gnt_val), 32'd1);

    // 5: owner never finishes while another channel waits.
    do_reset();
    req = 5'b00011;
    cycle();
    check("t5_gnt0", 32'(gnt_num), 32'd0);
    cycle(); cycle(); cycle();
    cycle();
    check("t5_owner", 32'(gnt_num), TMO_EN ? 32'd1 : 32'd0);
    check("t5_pulse", 32'(tmo), TMO_EN ? 32'd1 : 32'd0);
    cycle();
    check("t5_pulse_end", 32'(tmo), 32'd0);

    // 6: reset mid-grant restores priority 0.
    do_reset();
    req = 5'b00010;
    cycle();
    done = 1'b1; req = 5'b01000;
    cycle();
    check("t6_gnt3", 32'(gnt_num), 32'd3);
    done = 1'b0;
    rst = 1'b1;
    cycle();
    check("t6_rst_val", 32'(gnt_val), 32'd0);
    rst = 1'b0; req = 5'b01010;
    cycle();
    check("t6_gnt1", 32'(gnt_num), 32'd1);

    // Random traffic: requests persist for a few cycles, occasional done/reset.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      done = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      cycle();
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
